// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: write-back FSM states and datapath sizing.
package pipe_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 4;
    // The PC lives outside the register file, so it is not a legal write target.
    localparam logic [3:0]  PC_IDX     = 4'hF;
    localparam int unsigned NUM_GPR    = 15;

    typedef enum logic [0:0] {
        IDLE,
        LOAD_WAIT
    } wb_state_t;

endpackage

// File: rtl/wb_sat_counter.sv
// Saturating up-counter that bounds how long a load may stay outstanding.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clear    : return the count to 0 (takes priority over inc)
//   inc      : count one more cycle, holding at LIMIT
//   count    : current count
//   hit      : this edge brings the count to LIMIT (or keeps it there)
module wb_sat_counter #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned LIMIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             hit
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q < WIDTH'(LIMIT))) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign hit   = inc && !clear && (count_q >= WIDTH'(LIMIT - 1));

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: registers MEM results, selects ALU result or load data,
// and drives the register-file write port (also seen by forwarding).
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   freeze                  : global stall; blocks capture in IDLE only
//   mem_valid, wb_en_mem,
//   mem_r_en_mem, dest_mem,
//   alu_res_mem             : instruction arriving from MEM
//   mem_rdata,
//   mem_rdata_valid         : data-memory load return
//   wb_en_wb, dest_wb,
//   val_wb                  : register-file write triple (one-cycle enable)
//   mem_wait                : stall request while a load is outstanding
//   timeout_err             : sticky, load outstanding for TIMEOUT cycles
//   illegal_dest            : sticky, write to PC index attempted
//   retired_cnt             : instructions retired (wraps)
module wb_stage #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  mem_valid,
    input  logic                  wb_en_mem,
    input  logic                  mem_r_en_mem,
    input  logic [REG_ADDR_W-1:0] dest_mem,
    input  logic [DATA_W-1:0]     alu_res_mem,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_rdata_valid,
    output logic                  wb_en_wb,
    output logic [REG_ADDR_W-1:0] dest_wb,
    output logic [DATA_W-1:0]     val_wb,
    output logic                  mem_wait,
    output logic                  timeout_err,
    output logic                  illegal_dest,
    output logic [31:0]           retired_cnt
);

    import pipe_pkg::*;

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    wb_state_t             state_q, state_d;
    logic                  wb_en_q, wb_en_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0]     val_q, val_d;
    logic                  pend_we_q, pend_we_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  illegal_q, illegal_d;
    logic [31:0]           retired_q, retired_d;

    logic                  capture;
    logic                  retire;
    logic                  retire_we;
    logic [REG_ADDR_W-1:0] retire_dest;
    logic                  wait_inc;
    logic                  wait_clear;
    logic                  wait_hit;
    logic [CNT_W-1:0]      wait_cnt;

    assign capture    = (state_q == IDLE) && !freeze && mem_valid;
    assign wait_inc   = (state_q == LOAD_WAIT) && !mem_rdata_valid;
    assign wait_clear = !wait_inc;

    wb_sat_counter #(
        .WIDTH (CNT_W),
        .LIMIT (TIMEOUT)
    ) u_timeout_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (wait_clear),
        .inc   (wait_inc),
        .count (wait_cnt),
        .hit   (wait_hit)
    );

    always_comb begin
        state_d     = state_q;
        wb_en_d     = 1'b0;
        dest_d      = dest_q;
        val_d       = val_q;
        pend_we_d   = pend_we_q;
        retire      = 1'b0;
        retire_we   = 1'b0;
        retire_dest = dest_q;

        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    dest_d      = dest_mem;
                    retire_dest = dest_mem;
                    if (!mem_r_en_mem || mem_rdata_valid) begin
                        retire    = 1'b1;
                        retire_we = wb_en_mem;
                        val_d     = mem_r_en_mem ? mem_rdata : alu_res_mem;
                    end else begin
                        state_d   = LOAD_WAIT;
                        pend_we_d = wb_en_mem;
                    end
                end
            end
            LOAD_WAIT: begin
                // freeze is deliberately ignored: the load return must drain.
                if (mem_rdata_valid) begin
                    retire    = 1'b1;
                    retire_we = pend_we_q;
                    val_d     = mem_rdata;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // PC-targeted writes retire but are never committed.
        wb_en_d       = retire && retire_we && (retire_dest != REG_ADDR_W'(PC_IDX));
        illegal_d     = illegal_q
                      | (retire && retire_we && (retire_dest == REG_ADDR_W'(PC_IDX)));
        retired_d     = retire ? retired_q + 32'd1 : retired_q;
        timeout_err_d = timeout_err_q | wait_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wb_en_q       <= 1'b0;
            dest_q        <= '0;
            val_q         <= '0;
            pend_we_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            illegal_q     <= 1'b0;
            retired_q     <= '0;
        end else begin
            state_q       <= state_d;
            wb_en_q       <= wb_en_d;
            dest_q        <= dest_d;
            val_q         <= val_d;
            pend_we_q     <= pend_we_d;
            timeout_err_q <= timeout_err_d;
            illegal_q     <= illegal_d;
            retired_q     <= retired_d;
        end
    end

    assign wb_en_wb     = wb_en_q;
    assign dest_wb      = dest_q;
    assign val_wb       = val_q;
    assign mem_wait     = (state_q == LOAD_WAIT);
    assign timeout_err  = timeout_err_q;
    assign illegal_dest = illegal_q;
    assign retired_cnt  = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          freeze;
    logic          mem_valid;
    logic          wb_en_mem;
    logic          mem_r_en_mem;
    logic [AW-1:0] dest_mem;
    logic [DW-1:0] alu_res_mem;
    logic [DW-1:0] mem_rdata;
    logic          mem_rdata_valid;
    logic          wb_en_wb;
    logic [AW-1:0] dest_wb;
    logic [DW-1:0] val_wb;
    logic          mem_wait;
    logic          timeout_err;
    logic          illegal_dest;
    logic [31:0]   retired_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    wb_stage #(
        .DATA_W     (DW),
        .REG_ADDR_W (AW),
        .TIMEOUT    (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .mem_valid       (mem_valid),
        .wb_en_mem       (wb_en_mem),
        .mem_r_en_mem    (mem_r_en_mem),
        .dest_mem        (dest_mem),
        .alu_res_mem     (alu_res_mem),
        .mem_rdata       (mem_rdata),
        .mem_rdata_valid (mem_rdata_valid),
        .wb_en_wb        (wb_en_wb),
        .dest_wb         (dest_wb),
        .val_wb          (val_wb),
        .mem_wait        (mem_wait),
        .timeout_err     (timeout_err),
        .illegal_dest    (illegal_dest),
        .retired_cnt     (retired_cnt)
    );

    always #5 clk = ~clk;

    // Advance one posedge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        freeze          = 1'b0;
        mem_valid       = 1'b0;
        wb_en_mem       = 1'b0;
        mem_r_en_mem    = 1'b0;
        dest_mem        = '0;
        alu_res_mem     = '0;
        mem_rdata       = '0;
        mem_rdata_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #12;
        n_cmp++; if (wb_en_wb !== 1'b0) begin n_bad++;
            $display("FAIL reset_wb_en: got %b want 0", wb_en_wb); end
        n_cmp++; if (dest_wb !== 4'd0) begin n_bad++;
            $display("FAIL reset_dest: got %0d want 0", dest_wb); end
        n_cmp++; if (val_wb !== 32'd0) begin n_bad++;
            $display("FAIL reset_val: got %h want 0", val_wb); end
        n_cmp++; if (mem_wait !== 1'b0) begin n_bad++;
            $display("FAIL reset_mem_wait: got %b want 0", mem_wait); end
        n_cmp++; if ({timeout_err, illegal_dest} !== 2'b00) begin n_bad++;
            $display("FAIL reset_flags: got %b want 00", {timeout_err, illegal_dest}); end
        n_cmp++; if (retired_cnt !== 32'd0) begin n_bad++;
            $display("FAIL reset_retired: got %0d want 0", retired_cnt); end
        #2 rst = 1'b0;  // release away from a posedge
    endtask

    task automatic test_non_load();
        step();
        mem_valid = 1'b1; wb_en_mem = 1'b1; dest_mem = 4'd3; alu_res_mem = 32'h0000_00AA;
        step();
        mem_valid = 1'b0;
        n_cmp++; if ({wb_en_wb, dest_wb, val_wb} !== {1'b1, 4'd3, 32'h0000_00AA}) begin n_bad++;
            $display("FAIL nonload_write: got en=%b d=%0d v=%h want en=1 d=3 v=000000aa",
                     wb_en_wb, dest_wb, val_wb); end
        n_cmp++; if (retired_cnt !== 32'd1) begin n_bad++;
            $display("FAIL nonload_retired: got %0d want 1", retired_cnt); end
        step();
        n_cmp++; if ({wb_en_wb, val_wb} !== {1'b0, 32'h0000_00AA}) begin n_bad++;
            $display("FAIL nonload_hold: got en=%b v=%h want en=0 v=000000aa", wb_en_wb, val_wb); end
        n_cmp++; if (retired_cnt !== 32'd1) begin n_bad++;
            $display("FAIL nonload_retired_hold: got %0d want 1", retired_cnt); end
    endtask

    task automatic test_load_same_cycle();
        mem_valid = 1'b1; wb_en_mem = 1'b1; mem_r_en_mem = 1'b1; dest_mem = 4'd7;
        alu_res_mem = 32'h0000_1234; mem_rdata = 32'hDEAD_BEEF; mem_rdata_valid = 1'b1;
        #1;
        n_cmp++; if (mem_wait !== 1'b0) begin n_bad++;
            $display("FAIL load0_wait_pre: got %b want 0", mem_wait); end
        step();
        idle_inputs();
        n_cmp++; if ({wb_en_wb, dest_wb, val_wb} !== {1'b1, 4'd7, 32'hDEAD_BEEF}) begin n_bad++;
            $display("FAIL load0_write: got en=%b d=%0d v=%h want en=1 d=7 v=deadbeef",
                     wb_en_wb, dest_wb, val_wb); end
        n_cmp++; if ({mem_wait, retired_cnt} !== {1'b0, 32'd2}) begin n_bad++;
            $display("FAIL load0_wait_ret: got w=%b r=%0d want w=0 r=2", mem_wait, retired_cnt); end
    endtask

    task automatic test_load_latency();
        int wait_cycles = 0;
        mem_valid = 1'b1; wb_en_mem = 1'b1; mem_r_en_mem = 1'b1; dest_mem = 4'd5;
        alu_res_mem = 32'h0000_0055; mem_rdata = 32'h1111_1111; mem_rdata_valid = 1'b0;
        step();
        mem_valid = 1'b0; dest_mem = 4'd2;
        freeze = 1'b1;
        n_cmp++; if ({wb_en_wb, dest_wb} !== {1'b0, 4'd5}) begin n_bad++;
            $display("FAIL lat_capture: got en=%b d=%0d want en=0 d=5", wb_en_wb, dest_wb); end
        for (int i = 0; i < 3; i++) begin
            if (mem_wait === 1'b1) wait_cycles++;
            if (i == 2) begin
                mem_rdata = 32'hCAFE_F00D; mem_rdata_valid = 1'b1;
            end
            step();
        end
        n_cmp++; if (wait_cycles !== 3) begin n_bad++;
            $display("FAIL lat_wait_cycles: got %0d want 3", wait_cycles); end
        n_cmp++; if ({wb_en_wb, dest_wb, val_wb, mem_wait} !== {1'b1, 4'd5, 32'hCAFE_F00D, 1'b0})
        begin n_bad++;
            $display("FAIL lat_write: got en=%b d=%0d v=%h w=%b want en=1 d=5 v=cafef00d w=0",
                     wb_en_wb, dest_wb, val_wb, mem_wait); end
        n_cmp++; if (retired_cnt !== 32'd3) begin n_bad++;
            $display("FAIL lat_retired: got %0d want 3", retired_cnt); end
        idle_inputs();
        step();
        n_cmp++; if (wb_en_wb !== 1'b0) begin n_bad++;
            $display("FAIL lat_single_pulse: got %b want 0", wb_en_wb); end
    endtask

    task automatic test_illegal_freeze();
        mem_valid = 1'b1; wb_en_mem = 1'b1; dest_mem = 4'hF; alu_res_mem = 32'h0000_0077;
        step();
        n_cmp++; if ({wb_en_wb, illegal_dest} !== 2'b01) begin n_bad++;
            $display("FAIL illegal_supp: got en=%b ill=%b want en=0 ill=1", wb_en_wb, illegal_dest); end
        n_cmp++; if (retired_cnt !== 32'd4) begin n_bad++;
            $display("FAIL illegal_retired: got %0d want 4", retired_cnt); end
        freeze = 1'b1; dest_mem = 4'd2; alu_res_mem = 32'h0000_0099;
        step();
        step();
        n_cmp++; if ({wb_en_wb, dest_wb, val_wb} !== {1'b0, 4'hF, 32'h0000_0077}) begin n_bad++;
            $display("FAIL freeze_hold: got en=%b d=%0d v=%h want en=0 d=15 v=00000077",
                     wb_en_wb, dest_wb, val_wb); end
        n_cmp++; if ({retired_cnt, illegal_dest} !== {32'd4, 1'b1}) begin n_bad++;
            $display("FAIL freeze_retired: got r=%0d ill=%b want r=4 ill=1", retired_cnt, illegal_dest); end
        idle_inputs();
    endtask

    task automatic test_timeout();
        mem_valid = 1'b1; wb_en_mem = 1'b1; mem_r_en_mem = 1'b1; dest_mem = 4'd6;
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) step();
        n_cmp++; if ({timeout_err, mem_wait} !== 2'b01) begin n_bad++;
            $display("FAIL timeout_early: got err=%b w=%b want err=0 w=1", timeout_err, mem_wait); end
        step();
        n_cmp++; if ({timeout_err, mem_wait} !== 2'b11) begin n_bad++;
            $display("FAIL timeout_set: got err=%b w=%b want err=1 w=1", timeout_err, mem_wait); end
        step();
        n_cmp++; if ({timeout_err, mem_wait, wb_en_wb} !== 3'b110) begin n_bad++;
            $display("FAIL timeout_sticky: got err=%b w=%b en=%b want 1 1 0",
                     timeout_err, mem_wait, wb_en_wb); end
        rst = 1'b1;
        #2;
        n_cmp++; if ({wb_en_wb, dest_wb, val_wb, mem_wait, timeout_err, illegal_dest, retired_cnt}
                     !== {1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0}) begin n_bad++;
            $display("FAIL timeout_rst: got en=%b d=%0d v=%h w=%b err=%b ill=%b r=%0d want all 0",
                     wb_en_wb, dest_wb, val_wb, mem_wait, timeout_err, illegal_dest, retired_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        step();
        mem_valid = 1'b1; wb_en_mem = 1'b1; mem_r_en_mem = 1'b1; dest_mem = 4'd9;
        step();
        idle_inputs();
        n_cmp++; if (mem_wait !== 1'b1) begin n_bad++;
            $display("FAIL midrst_entered: got %b want 1", mem_wait); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (mem_wait !== 1'b0) begin n_bad++;
            $display("FAIL midrst_wait_drop: got %b want 0", mem_wait); end
        #1 rst = 1'b0;
        mem_rdata = 32'h5555_AAAA; mem_rdata_valid = 1'b1;
        step();
        step();
        mem_rdata_valid = 1'b0;
        n_cmp++; if ({wb_en_wb, val_wb, retired_cnt} !== {1'b0, 32'd0, 32'd0}) begin n_bad++;
            $display("FAIL midrst_no_write: got en=%b v=%h r=%0d want en=0 v=0 r=0",
                     wb_en_wb, val_wb, retired_cnt); end
    endtask

    initial begin
        test_reset();
        test_non_load();
        test_load_same_cycle();
        test_load_latency();
        test_illegal_freeze();
        test_timeout();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the ARM32 pipeline; the producer side of the register file write port.
- Registers MEM-stage results at posedge clk and selects ALU result or load data.
- Drives a one-cycle write enable, destination and value, which the register file commits on the following negedge.
- Absorbs variable-latency data-memory load returns with a small FSM that stalls the pipeline, and exports the same triple to the forwarding unit.

Parameters:
- DATA_W, 32, datapath width.
- REG_ADDR_W, 4, register index width.
- TIMEOUT, 64, maximum cycles spent in LOAD_WAIT before the error flag is raised.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- freeze  input  1  global stall from hazard unit; blocks capture.
- mem_valid  input  1  MEM stage holds a valid instruction.
- wb_en_mem  input  1  instruction writes a register.
- mem_r_en_mem  input  1  instruction is a load.
- dest_mem  input  REG_ADDR_W  destination register index.
- alu_res_mem  input  DATA_W  ALU/address result.
- mem_rdata  input  DATA_W  load data from data memory.
- mem_rdata_valid  input  1  mem_rdata is valid this cycle.
- wb_en_wb  output  1  register-file write enable, one-cycle pulse.
- dest_wb  output  REG_ADDR_W  write destination; also feeds the forwarding unit.
- val_wb  output  DATA_W  write value; also feeds the forwarding unit.
- mem_wait  output  1  stall request to all earlier stages.
- timeout_err  output  1  sticky: a load waited longer than TIMEOUT cycles.
- illegal_dest  output  1  sticky: a write to index 15 was attempted.
- retired_cnt  output  32  count of instructions retired through WB.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0. Reset asserted mid-LOAD_WAIT aborts the load, and no write is issued.
- Capture condition: posedge with state==IDLE, !freeze, mem_valid.
- IDLE, capture of a non-load: next cycle wb_en_wb=wb_en_mem, dest_wb=dest_mem, val_wb=alu_res_mem. Latency is 1 cycle.
- IDLE, capture of a load with mem_rdata_valid=1 at the same edge: val_wb=mem_rdata, wb_en_wb=wb_en_mem next cycle.
- IDLE, capture of a load with mem_rdata_valid=0: go to LOAD_WAIT.
  - Latch dest_mem and wb_en_mem; wb_en_wb=0.
  - mem_wait is asserted combinationally whenever state==LOAD_WAIT.
- LOAD_WAIT, each posedge:
  - mem_rdata_valid=1: latch val_wb=mem_rdata, pulse wb_en_wb for 1 cycle, return to IDLE, clear the counter.
  - Otherwise: increment the counter (saturating).
  - Counter reaches TIMEOUT: set timeout_err (sticky until rst). Keep waiting; the pipeline stays stalled.
- freeze is ignored in LOAD_WAIT; the load return takes priority. freeze=1 in IDLE means no capture.
- wb_en_wb is 0 on every cycle without a new retirement. dest_wb and val_wb hold their last values, so the register file never double-writes.
- mem_rdata_valid while in IDLE with no load captured is ignored.
- dest 15 (4'hF, PC, not held in the register file): wb_en_wb is forced to 0 and illegal_dest is set sticky. The instruction still counts as retired.
- retired_cnt increments by 1 on each cycle that follows a retirement (the wb_en pulse cycle, including suppressed or no-write instructions). Wraps modulo 2^32.
- Outputs change only on posedge, so they are stable at the register file's negedge write and a same-cycle ID read sees the new value.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum {IDLE, LOAD_WAIT} wb_state_t.
  - REG_ADDR_W, DATA_W.
  - PC_IDX=4'hF.
  - NUM_GPR=15.
- One sub-module is natural: wb_sat_counter (saturating timeout counter, parameterised width/limit).
- The rest is inline.

Test Plan:
- Non-load: alu_res_mem=32'h0000_00AA, dest_mem=3, wb_en_mem=1, mem_valid=1 -> next cycle wb_en_wb=1, dest_wb=3, val_wb=0xAA; following cycle wb_en_wb=0; retired_cnt=1.
- Load, same-cycle data: mem_r_en_mem=1, mem_rdata=32'hDEAD_BEEF, mem_rdata_valid=1, dest=7 -> next cycle val_wb=0xDEADBEEF, wb_en_wb=1, mem_wait never high.
- Load, 3-cycle latency: mem_rdata_valid rises 3 cycles after capture -> mem_wait=1 for exactly 3 cycles, then a single wb_en_wb pulse with dest=5 and the returned data; freeze asserted during the wait has no effect.
- Timeout: TIMEOUT=4, data never returns -> timeout_err=1 after 4 wait cycles, mem_wait stays 1; apply rst -> all outputs 0, state IDLE.
- Illegal dest and freeze: dest_mem=15, wb_en_mem=1 -> wb_en_wb=0, illegal_dest=1, retired_cnt+1; then freeze=1 with a valid instruction presented -> no capture, outputs held, wb_en_wb=0.
- Reset mid-wait: rst pulsed asynchronously between clock edges while in LOAD_WAIT -> immediate mem_wait=0; a later mem_rdata_valid produces no write.
